// File: rtl/muldiv_sequencer_pkg.sv
// ============================================================================
//  Module  : muldiv_pkg
//  Desc    : Shared types and constants for the HI/LO multiply/divide
//            sequencer (state encoding, widths, special operand values).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DATA_W) + 1;

    localparam logic [DATA_W-1:0] INT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_sequencer_if.sv
// ============================================================================
//  Module  : muldiv_sequencer_if
//  Desc    : Start/operand/result bundle between the main control FSM
//            (master) and the multiply/divide sequencer (slave).
//            Optional macro MULDIV_UNSIGNED_EN adds the is_unsigned signal.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface muldiv_sequencer_if #(
    parameter int DATA_W = muldiv_pkg::DATA_W
) ();
    logic              start_mult;
    logic              start_div;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
`ifdef MULDIV_UNSIGNED_EN
    logic              is_unsigned;
`endif
    logic              busy;
    logic              done;
    logic              div_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

`ifdef MULDIV_UNSIGNED_EN
    modport master (output start_mult, start_div, op_a, op_b, is_unsigned,
                    input  busy, done, div_zero, hi, lo);
    modport slave  (input  start_mult, start_div, op_a, op_b, is_unsigned,
                    output busy, done, div_zero, hi, lo);
`else
    modport master (output start_mult, start_div, op_a, op_b,
                    input  busy, done, div_zero, hi, lo);
    modport slave  (input  start_mult, start_div, op_a, op_b,
                    output busy, done, div_zero, hi, lo);
`endif

endinterface

`default_nettype wire

// File: rtl/muldiv_sequencer_div_step.sv
// ============================================================================
//  Module  : div_step
//  Desc    : One restoring-division step on magnitudes: shift the next
//            dividend bit into the partial remainder and subtract the
//            divisor if it fits.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic              bit_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_o
);

    // Two guard bits: the shifted remainder can reach 2*divisor-1.
    logic [DATA_W+1:0] w_shift;
    logic [DATA_W+1:0] w_trial;

    // Trial subtraction; a clear borrow bit means the divisor fits.
    always_comb begin
        w_shift = {1'b0, rem_i, bit_i};
        w_trial = w_shift - {2'b00, dvs_i};
        q_o     = ~w_trial[DATA_W+1];
        rem_o   = q_o ? w_trial[DATA_W-1:0] : w_shift[DATA_W-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
//  Module  : muldiv_sequencer
//  Desc    : Iterative signed MULT (radix-2 Booth) / DIV (restoring) engine
//            writing a 2*DATA_W result into HI/LO, with a divide-by-zero
//            event pulse. Optional macro MULDIV_UNSIGNED_EN enables
//            MULTU/DIVU via the is_unsigned interface signal.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
    parameter int DATA_W = muldiv_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus
);
    import muldiv_pkg::*;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // Product register: DATA_W+1 accumulator (one guard bit so -INT_MIN
    // is representable), DATA_W multiplier bits, one Booth history bit.
    logic [2*DATA_W+1:0] prod_q, prod_d, w_booth;
    logic [DATA_W:0]     mcand_q, mcand_d, w_upper;
    logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                mul_q, mul_d, corr_q, corr_d;
    logic                negq_q, negq_d, negr_q, negr_d;
    logic                done_q, done_d, dz_q, dz_d;
    logic [DATA_W-1:0]   w_rem_nx, w_a_mag, w_b_mag;
    logic                w_qbit, w_uns, w_a_neg, w_b_neg;
    logic [2*DATA_W-1:0] w_mres;

`ifdef MULDIV_UNSIGNED_EN
    assign w_uns = bus.is_unsigned;
`else
    assign w_uns = 1'b0;
`endif

    assign w_a_neg = ~w_uns & bus.op_a[DATA_W-1];
    assign w_b_neg = ~w_uns & bus.op_b[DATA_W-1];
    assign w_a_mag = w_a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
    assign w_b_mag = w_b_neg ? (~bus.op_b + 1'b1) : bus.op_b;

    div_step #(.DATA_W(DATA_W)) u_div_step (
        .rem_i (rem_q),
        .bit_i (quo_q[DATA_W-1]),
        .dvs_i (dvs_q),
        .rem_o (w_rem_nx),
        .q_o   (w_qbit)
    );

    // Booth step: add/subtract multiplicand per bit pair, then arithmetic shift.
    always_comb begin
        w_upper = prod_q[2*DATA_W+1:DATA_W+1];
        case (prod_q[1:0])
            2'b01:   w_upper = prod_q[2*DATA_W+1:DATA_W+1] + mcand_q;
            2'b10:   w_upper = prod_q[2*DATA_W+1:DATA_W+1] - mcand_q;
            default: w_upper = prod_q[2*DATA_W+1:DATA_W+1];
        endcase
        w_booth = {w_upper[DATA_W], w_upper, prod_q[DATA_W:1]};
    end

    // Final product; unsigned mode folds back the weight of the multiplier MSB.
    always_comb begin
        w_mres = prod_q[2*DATA_W:1];
        if (corr_q) begin
            w_mres = prod_q[2*DATA_W:1] + {mcand_q[DATA_W-1:0], {DATA_W{1'b0}}};
        end
    end

    // Next-state, datapath and output-pulse logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mul_d   = mul_q;
        corr_d  = corr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_mult) begin
                    state_d = MULT;
                    cnt_d   = CNT_W'(DATA_W);
                    mul_d   = 1'b1;
                    mcand_d = {w_a_neg, bus.op_a};
                    prod_d  = {{(DATA_W+1){1'b0}}, bus.op_b, 1'b0};
                    corr_d  = w_uns & bus.op_b[DATA_W-1];
                end else if (bus.start_div) begin
                    if (bus.op_b == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        state_d = DIV;
                        cnt_d   = CNT_W'(DATA_W);
                        mul_d   = 1'b0;
                        rem_d   = '0;
                        quo_d   = w_a_mag;
                        dvs_d   = w_b_mag;
                        negq_d  = w_a_neg ^ w_b_neg;
                        negr_d  = w_a_neg;
                    end
                end
            end
            MULT: begin
                prod_d = w_booth;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIN;
            end
            DIV: begin
                rem_d = w_rem_nx;
                quo_d = {quo_q[DATA_W-2:0], w_qbit};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIN;
            end
            FIN: begin
                if (mul_q) begin
                    {hi_d, lo_d} = w_mres;
                end else begin
                    lo_d = negq_q ? (~quo_q + 1'b1) : quo_q;
                    hi_d = negr_q ? (~rem_q + 1'b1) : rem_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mul_q   <= 1'b0;
            corr_q  <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mul_q   <= mul_d;
            corr_q  <= corr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
//  Module  : tb_muldiv_sequencer
//  Desc    : Directed self-checking bench for muldiv_sequencer (default
//            signed build).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

    localparam int LAT = 33;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one operation, optionally pulse a stray start_div at cycle inj,
    // then check latency, busy span, result and absence of div_zero.
    task automatic do_op(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b, input int inj,
                         input logic [31:0] ehi, input logic [31:0] elo);
        int   lat;
        int   bcnt;
        logic dz;
        @(negedge clk);
        bus.start_mult = m;
        bus.start_div  = d;
        bus.op_a       = a;
        bus.op_b       = b;
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_a       = 32'hDEAD_BEEF;
        bus.op_b       = 32'h0000_0000;
        lat  = 0;
        bcnt = 0;
        dz   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done) break;
            if (bus.busy) bcnt++;
            if (bus.div_zero) dz = 1'b1;
            bus.start_div = (lat == inj);
            if (lat == inj) bus.op_b = 32'd5;
            @(posedge clk); #1;
            lat++;
        end
        bus.start_div = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " busy_cycles"}, 64'(bcnt), 64'(LAT));
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, " div_zero"}, 64'(dz | bus.div_zero), 64'd0);
        check({tag, " hi"}, 64'(bus.hi), 64'(ehi));
        check({tag, " lo"}, 64'(bus.lo), 64'(elo));
    endtask

    task automatic count_done(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.done) n++;
        end
        check({tag, " extra_done"}, 64'(n), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
`ifdef MULDIV_UNSIGNED_EN
        bus.is_unsigned = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst div_zero", 64'(bus.div_zero), 64'd0);
        check("rst hi", 64'(bus.hi), 64'd0);
        check("rst lo", 64'(bus.lo), 64'd0);
        reset = 1'b1;

        // Signed multiply / divide vectors (back-to-back starts in done cycle).
        do_op("mul 7*-3",      1, 0, 32'd7,         32'hFFFF_FFFD, -1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("mul min*min",   1, 0, 32'h8000_0000, 32'h8000_0000, -1, 32'h4000_0000, 32'h0000_0000);
        do_op("mul -1*-1",     1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 32'h0000_0000, 32'h0000_0001);
        do_op("div -7/2",      0, 1, 32'hFFFF_FFF9, 32'd2,         -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div 100/-7",    0, 1, 32'd100,       32'hFFFF_FFF9, -1, 32'h0000_0002, 32'hFFFF_FFF2);
        do_op("div -100/7",    0, 1, 32'hFFFF_FF9C, 32'd7,         -1, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        do_op("div min/-1",    0, 1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'h0000_0000, 32'h8000_0000);
        do_op("div 0x451/32",  0, 1, 32'h0000_0451, 32'h0000_0020, -1, 32'h0000_0011, 32'h0000_0022);

        // Divide by zero: one-cycle event, no busy, HI/LO retained.
        @(negedge clk);
        bus.start_div = 1'b1;
        bus.op_a      = 32'd5;
        bus.op_b      = 32'd0;
        @(posedge clk); #1;
        bus.start_div = 1'b0;
        check("dz cycle1 div_zero", 64'(bus.div_zero), 64'd1);
        check("dz cycle1 busy", 64'(bus.busy), 64'd0);
        check("dz cycle1 done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        check("dz cycle2 div_zero", 64'(bus.div_zero), 64'd0);
        check("dz cycle2 busy", 64'(bus.busy), 64'd0);
        check("dz hi", 64'(bus.hi), 64'h11);
        check("dz lo", 64'(bus.lo), 64'h22);

        // Simultaneous starts: multiply wins; stray start_div at cycle 10 ignored.
        do_op("both 3,4", 1, 1, 32'd3, 32'd4, 10, 32'd0, 32'd12);
        count_done("both 3,4", 40);

        // Asynchronous reset mid-multiply aborts and clears HI/LO.
        @(negedge clk);
        bus.start_mult = 1'b1;
        bus.op_a       = 32'h0001_0000;
        bus.op_b       = 32'h0001_0000;
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst mid busy", 64'(bus.busy), 64'd0);
        check("rst mid hi", 64'(bus.hi), 64'd0);
        check("rst mid lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        count_done("after rst", 40);
        do_op("mul 2^16*2^16", 1, 0, 32'h0001_0000, 32'h0001_0000, -1, 32'h0000_0001, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
